// File: rtl/jt7759_pkg.sv
// Shared constants for the JT7759 slave-mode byte buffer:
// serve FSM encoding and the default FIFO depth.
package jt7759_pkg;

   localparam int FIFO_AW = 2;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'b001,
      ST_FETCH = 3'b010,
      ST_HOLD  = 3'b100
   } srv_state_e;

endpackage

// File: rtl/jt7759_fifo.sv
// Byte FIFO filled by CPU writes and drained by the serve FSM.
// Pointers carry one extra MSB so full and empty can be told apart.
module jt7759_fifo
   import jt7759_pkg::*;
#(
   parameter int AW = FIFO_AW
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       empty,
   output logic       full_next,
   output logic       ovf
);

   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic        ovf_q, ovf_d;
   logic        full, wr_en, rd_en;
   logic [7:0]  mem_q [2**AW];

   // A push into a full FIFO is only accepted when a pop frees a slot in the same cycle
   always_comb begin
      empty     = (wr_ptr_q == rd_ptr_q);
      full      = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
      rd_en     = pop && !empty && !clr;
      wr_en     = push && (!full || rd_en) && !clr;
      wr_ptr_d  = wr_ptr_q + (AW+1)'(wr_en);
      rd_ptr_d  = rd_ptr_q + (AW+1)'(rd_en);
      ovf_d     = ovf_q || (push && full && !rd_en);
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         ovf_d    = 1'b0;
      end
      full_next = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[AW] != rd_ptr_d[AW]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= din;
   end

   assign dout = mem_q[rd_ptr_q[AW-1:0]];
   assign ovf  = ovf_q;

endmodule

// File: rtl/jt7759_slvbuf.sv
// ROM-port byte source for the JT7759 controller: external ROM pass-through in
// stand-alone mode, CPU-filled FIFO served one byte per address change in slave mode.
module jt7759_slvbuf
   import jt7759_pkg::*;
#(
   parameter int AW = FIFO_AW
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mdn,
   input  logic        cs,
   input  logic        wrn,
   input  logic [7:0]  din,
   input  logic        flush,
   output logic        drqn,
   output logic        ovf,
   input  logic        ctl_cs,
   input  logic [16:0] ctl_addr,
   output logic [7:0]  ctl_data,
   output logic        ctl_ok,
   output logic        rom_cs,
   output logic [16:0] rom_addr,
   input  logic [7:0]  rom_data,
   input  logic        rom_ok
);

   srv_state_e  state_q, state_d;
   logic        last_wr_q, last_wr_d;
   logic        mdn_q, mdn_d;
   logic        drqn_q, drqn_d;
   logic        ctl_ok_q, ctl_ok_d;
   logic [7:0]  ctl_data_q, ctl_data_d;
   logic [16:0] last_addr_q, last_addr_d;
   logic        wr_now, push, pop, clr;
   logic        fifo_empty, fifo_full_next;
   logic [7:0]  fifo_dout;

   jt7759_fifo #(.AW(AW)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .push      (push),
      .pop       (pop),
      .din       (din),
      .dout      (fifo_dout),
      .empty     (fifo_empty),
      .full_next (fifo_full_next),
      .ovf       (ovf)
   );

   // The registered mdn keeps the FIFO cleared for one extra cycle after leaving stand-alone mode
   always_comb begin
      wr_now      = cs && !wrn;
      push        = wr_now && !last_wr_q;
      clr         = flush || mdn || mdn_q;
      last_wr_d   = wr_now;
      mdn_d       = mdn;
      state_d     = state_q;
      ctl_ok_d    = 1'b0;
      ctl_data_d  = ctl_data_q;
      last_addr_d = last_addr_q;
      pop         = 1'b0;
      if (clr) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (ctl_cs) state_d = ST_FETCH;
            ST_FETCH: begin
               if (!ctl_cs) begin
                  state_d = ST_IDLE;
               end else if (!fifo_empty) begin
                  pop         = 1'b1;
                  ctl_data_d  = fifo_dout;
                  last_addr_d = ctl_addr;
                  ctl_ok_d    = 1'b1;
                  state_d     = ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (!ctl_cs)                       state_d = ST_IDLE;
               else if (ctl_addr != last_addr_q)  state_d = ST_FETCH;
               else                               ctl_ok_d = 1'b1;
            end
            default: state_d = ST_IDLE;
         endcase
      end
      drqn_d = mdn ? 1'b1 : !(ctl_cs && !fifo_full_next);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         last_wr_q   <= 1'b0;
         mdn_q       <= 1'b0;
         drqn_q      <= 1'b1;
         ctl_ok_q    <= 1'b0;
         ctl_data_q  <= 8'd0;
         last_addr_q <= 17'd0;
      end else begin
         state_q     <= state_d;
         last_wr_q   <= last_wr_d;
         mdn_q       <= mdn_d;
         drqn_q      <= drqn_d;
         ctl_ok_q    <= ctl_ok_d;
         ctl_data_q  <= ctl_data_d;
         last_addr_q <= last_addr_d;
      end
   end

   assign rom_cs   = mdn ? ctl_cs   : 1'b0;
   assign rom_addr = mdn ? ctl_addr : 17'd0;
   assign ctl_data = mdn ? rom_data : ctl_data_q;
   assign ctl_ok   = mdn ? rom_ok   : ctl_ok_q;
   assign drqn     = drqn_q;

endmodule

// File: tb/tb_jt7759_slvbuf.sv
// Bench for jt7759_slvbuf: directed scenarios then randomized push/read traffic
// compared against a queue-based model of the byte buffer.
module tb_jt7759_slvbuf;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        mdn, cs, wrn, flush;
   logic [7:0]  din;
   logic        drqn, ovf;
   logic        ctl_cs;
   logic [16:0] ctl_addr;
   logic [7:0]  ctl_data;
   logic        ctl_ok;
   logic        rom_cs;
   logic [16:0] rom_addr;
   logic [7:0]  rom_data;
   logic        rom_ok;

   int          checkCnt = 0;
   int          passCnt  = 0;
   logic [7:0]  modelQ[$];
   logic        ovfM = 1'b0;
   logic [16:0] addrReg = 17'd0;

   jt7759_slvbuf #(.AW(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .mdn      (mdn),
      .cs       (cs),
      .wrn      (wrn),
      .din      (din),
      .flush    (flush),
      .drqn     (drqn),
      .ovf      (ovf),
      .ctl_cs   (ctl_cs),
      .ctl_addr (ctl_addr),
      .ctl_data (ctl_data),
      .ctl_ok   (ctl_ok),
      .rom_cs   (rom_cs),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .rom_ok   (rom_ok)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCnt++;
      if (got === exp) passCnt++;
      else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One CPU write strobe; the model keeps at most DEPTH bytes and flags overflow
   task automatic applyStimulus(input logic [7:0] b);
      cs = 1'b1; wrn = 1'b0; din = b;
      tick();
      cs = 1'b0; wrn = 1'b1;
      tick();
      if (modelQ.size() < DEPTH) modelQ.push_back(b);
      else ovfM = 1'b1;
   endtask

   task automatic readOne(input logic [7:0] stallByte);
      int waitCnt;
      logic [7:0] expB;
      addrReg  = addrReg + 17'd1;
      ctl_addr = addrReg;
      ctl_cs   = 1'b1;
      tick();
      checkOutput("okDrop", ctl_ok, 0);
      if (modelQ.size() == 0) begin
         repeat (2) begin
            tick();
            checkOutput("stallOk", ctl_ok, 0);
         end
         checkOutput("stallDrqn", drqn, 0);
         applyStimulus(stallByte);
      end
      waitCnt = 0;
      while (!ctl_ok && waitCnt < 6) begin
         tick();
         waitCnt++;
      end
      checkOutput("okTimeout", ctl_ok, 1);
      expB = (modelQ.size() > 0) ? modelQ.pop_front() : 8'hxx;
      checkOutput("readData", ctl_data, expB);
   endtask

   initial begin
      rst = 1'b1; mdn = 1'b0; cs = 1'b0; wrn = 1'b1; flush = 1'b0; din = 8'd0;
      ctl_cs = 1'b0; ctl_addr = 17'd0; rom_data = 8'd0; rom_ok = 1'b0;
      #23;
      checkOutput("rstDrqn", drqn, 1);
      checkOutput("rstOvf", ovf, 0);
      checkOutput("rstData", ctl_data, 0);
      checkOutput("rstOk", ctl_ok, 0);
      checkOutput("rstRomCs", rom_cs, 0);
      checkOutput("rstRomAddr", rom_addr, 0);
      @(posedge clk); #1; rst = 1'b0;
      tick();

      // stand-alone pass-through
      mdn = 1'b1; ctl_cs = 1'b1; ctl_addr = 17'h00005; rom_data = 8'h5A; rom_ok = 1'b1;
      #1;
      checkOutput("saRomCs", rom_cs, 1);
      checkOutput("saRomAddr", rom_addr, 17'h00005);
      checkOutput("saData", ctl_data, 8'h5A);
      checkOutput("saOk", ctl_ok, 1);
      tick();
      checkOutput("saDrqn", drqn, 1);
      mdn = 1'b0; ctl_cs = 1'b0; rom_ok = 1'b0;
      #1;
      checkOutput("slvRomAddr", rom_addr, 0);
      tick(); tick();

      // slave basic with exact two-cycle latency
      applyStimulus(8'h11);
      applyStimulus(8'h22);
      ctl_addr = 17'h00003; ctl_cs = 1'b1; addrReg = 17'h00004;
      tick();
      checkOutput("basicLat1", ctl_ok, 0);
      tick();
      checkOutput("basicOk1", ctl_ok, 1);
      checkOutput("basicData1", ctl_data, modelQ.pop_front());
      ctl_addr = 17'h00004;
      tick();
      checkOutput("basicDrop", ctl_ok, 0);
      tick();
      checkOutput("basicOk2", ctl_ok, 1);
      checkOutput("basicData2", ctl_data, modelQ.pop_front());

      // empty stall then a single push
      readOne(8'h7F);

      // fill to full, then push and pop in the same cycle
      for (int i = 1; i <= DEPTH; i++) begin
         applyStimulus(8'hA0 + 8'(i));
         checkOutput("fillDrqn", drqn, (modelQ.size() == DEPTH) ? 1 : 0);
      end
      addrReg = addrReg + 17'd1; ctl_addr = addrReg;
      tick();
      cs = 1'b1; wrn = 1'b0; din = 8'hB6;
      tick();
      checkOutput("simOvf", ovf, 0);
      checkOutput("simOk", ctl_ok, 1);
      checkOutput("simData", ctl_data, modelQ.pop_front());
      modelQ.push_back(8'hB6);
      cs = 1'b0; wrn = 1'b1;
      tick();
      checkOutput("simFullDrqn", drqn, 1);

      // overflow: fifth byte dropped
      applyStimulus(8'hC5);
      checkOutput("ovfSet", ovf, ovfM);
      for (int i = 0; i < DEPTH; i++) readOne(8'h00);
      checkOutput("ovfSticky", ovf, 1);

      // flush with three bytes queued
      for (int i = 0; i < 3; i++) applyStimulus(8'hD0 + 8'(i));
      flush = 1'b1;
      tick();
      flush = 1'b0;
      modelQ.delete(); ovfM = 1'b0;
      checkOutput("flushOk", ctl_ok, 0);
      checkOutput("flushOvf", ovf, 0);
      tick(); tick();
      checkOutput("flushEmpty", ctl_ok, 0);
      checkOutput("flushDrqn", drqn, 0);
      readOne(8'h3C);

      // asynchronous reset while holding a byte
      checkOutput("preRstOk", ctl_ok, 1);
      #3 rst = 1'b1;
      #1;
      checkOutput("midRstOk", ctl_ok, 0);
      checkOutput("midRstData", ctl_data, 0);
      checkOutput("midRstDrqn", drqn, 1);
      checkOutput("midRstOvf", ovf, 0);
      tick();
      rst = 1'b0;
      modelQ.delete(); ovfM = 1'b0;
      readOne(8'h44);

      // randomized traffic against the queue model
      for (int iter = 0; iter < 60; iter++) begin
         int k;
         int r;
         k = $urandom_range(0, 5);
         for (int j = 0; j < k; j++) applyStimulus(8'($urandom));
         checkOutput("rndDrqn", drqn, (modelQ.size() == DEPTH) ? 1 : 0);
         checkOutput("rndOvf", ovf, ovfM);
         if ($urandom_range(0, 7) == 0) begin
            flush = 1'b1;
            tick();
            flush = 1'b0;
            modelQ.delete(); ovfM = 1'b0;
            checkOutput("rndFlushOvf", ovf, 0);
            readOne(8'($urandom));
         end
         r = $urandom_range(1, 4);
         for (int j = 0; j < r; j++) readOne(8'($urandom));
      end

      $display("%0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end

endmodule

// File: doc/jt7759_slvbuf.md
# jt7759_slvbuf

Byte source for the JT7759 controller's ROM port. In stand-alone mode (`mdn`=1) it passes the external ROM through. In slave mode (`mdn`=0) it serves the controller's byte requests from a small FIFO filled by CPU writes, and raises a data request (`drqn`) when it has room. It sits between `jt7759_ctrl` and the system ROM/CPU bus, inside the jt7759 top level.

## Interface
Parameters:
- `AW`, 2: FIFO address width; depth = 2**`AW` bytes.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous and active-high.
- `mdn`  in  1  1 = stand-alone (ROM pass-through), 0 = slave (FIFO).
- `cs`  in  1  CPU chip select.
- `wrn`  in  1  CPU write strobe, active low.
- `din`  in  8  CPU data.
- `flush`  in  1  synchronous FIFO clear, one-cycle pulse.
- `drqn`  out  1  data request to CPU, active low.
- `ovf`  out  1  sticky overflow flag, cleared by `flush` or `rst`.
- `ctl_cs`  in  1  controller `rom_cs`.
- `ctl_addr`  in  17  controller `rom_addr`.
- `ctl_data`  out  8  byte returned to the controller.
- `ctl_ok`  out  1  `ctl_data` valid for the current `ctl_addr`.
- `rom_cs`  out  1  external ROM select.
- `rom_addr`  out  17  external ROM address.
- `rom_data`  in  8  external ROM data.
- `rom_ok`  in  1  external ROM data valid.

## Operation
- **Stand-alone mode (`mdn`=1).** Combinational pass-through: `rom_cs`=`ctl_cs`, `rom_addr`=`ctl_addr`, `ctl_data`=`rom_data`, `ctl_ok`=`rom_ok`.
  - FIFO logic is held cleared.
  - `drqn`=1.
- **Slave mode (`mdn`=0).** `rom_cs`=0 and `rom_addr`=0.
- **CPU push.** A push happens on the cycle where `cs && !wrn` is true and was false the cycle before (falling-edge detect on registered `last_wr`).
  - `din` is written at the write pointer.
  - If the FIFO is full and no pop happens that cycle, the byte is dropped and `ovf` is set.
- **Serve FSM.** Three states:
  - IDLE: `ctl_ok`=0. Moves to FETCH when `ctl_cs`=1.
  - FETCH: `ctl_ok`=0. If the FIFO is not empty, pop into the `ctl_data` register, latch `ctl_addr` into `last_addr`, and go to HOLD. If empty, wait in FETCH. If `ctl_cs` falls, go to IDLE.
  - HOLD: `ctl_ok`=1. If `ctl_cs`=0, go to IDLE. If `ctl_cs`=1 and `ctl_addr`≠`last_addr`, drop `ctl_ok` that cycle and go to FETCH.
- **Addresses are not decoded in slave mode.** Any address change is a new sequential byte request, including jumps (LOAD, repeat).
- **Pointers.** Width `AW`+1; the MSB distinguishes full from empty.
  - Empty = pointers equal.
  - Full = low bits equal and MSBs differ.
  - Pointers wrap modulo 2**(`AW`+1).
- **Simultaneous push and pop.** Both are honoured; the count is unchanged. When full, the push is accepted (no `ovf`).
- **Push into empty FIFO while in FETCH.** The byte is popped on the next cycle. There is no same-cycle bypass.
- **Request line.** `drqn` is registered: `drqn` <= !(`ctl_cs` && !full_next), where full_next is the occupancy after this cycle's push/pop.
- **Flush.** `flush` resets the pointers, clears `ovf`, and sends the FSM to IDLE. A push in the same cycle is discarded.
- **Mode change.** Switching `mdn` mid-operation acts as a flush on the next cycle.

## Timing
- Reset values:
  - `drqn`=1, `ovf`=0, `ctl_data`=0, `ctl_ok`=0.
  - `rom_cs`/`rom_addr` follow `mdn` combinationally (0 when `mdn`=0).
  - Pointers=0, FSM=IDLE, `last_wr`=0, `last_addr`=0.
- Slave-mode latency, new address to `ctl_ok`=1: 2 cycles when data is present (FETCH entry, then pop registers into HOLD). Add 2 cycles per push when empty (edge detect + write).
- `ctl_ok` is registered and drops in the same cycle the FSM leaves HOLD.
- Throughput: one byte per 2 cycles, comfortably above the controller's `cen4`/`cendec` rates.
- Stand-alone path: zero-cycle combinational.

## Structure
- Shared constants in `jt7759_pkg`: FSM state encoding (one-hot, 3 bits) and the FIFO depth default.
- One natural sub-module: `jt7759_fifo`.
  - Contains storage, pointers, full/empty and overflow.
  - Instantiated once.
- The FSM and the mode mux live in the top of this block.

## Test plan
- **Stand-alone:** `mdn`=1, `ctl_addr`=0x00005, `rom_data`=0x5A, `rom_ok`=1 -> same-cycle `rom_addr`=0x00005, `ctl_data`=0x5A, `ctl_ok`=1; `drqn`=1.
- **Slave basic:** push 0x11, 0x22. `ctl_cs`=1 at addr 0x00003 -> `ctl_ok`=1 with 0x11 two cycles later. Addr becomes 0x00004 -> `ctl_ok` drops, then returns with 0x22.
- **Empty stall:** `ctl_cs`=1, FIFO empty -> `ctl_ok` stays 0 and `drqn`=0. Push 0x7F -> `ctl_ok`=1 with 0x7F within 4 cycles.
- **Full/overflow:** `AW`=2, push 5 bytes with no pops -> `drqn`=1 after the 4th push. The 5th is dropped, `ovf`=1. Later pops return bytes 1–4 in order.
- **Simultaneous push/pop at full:** push and an address change in the same cycle -> `ovf` stays 0, occupancy stays 4, order preserved across pointer wrap.
- **Reset/flush mid-operation:** assert `rst` while in HOLD -> all outputs at reset values immediately. Separately, `flush` with 3 bytes queued -> FIFO empty, FSM IDLE, `ovf`=0.
